// File: rtl/snes_pad_tx.sv
// SNES controller emulator: captures a button word while the console holds LATCH
// high, then shifts it out active-low, LSB first, on each console CLK rising edge.
module snes_pad_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int NBITS       = 16
) (
  input  logic             CLK_i,
  input  logic             RST_i,
  input  logic             CTRL_LATCH_i,
  input  logic             CTRL_CLK_i,
  input  logic [NBITS-1:0] BUTTONS_i,
  output logic             CTRL_SDATA_o,
  output logic             CTRL_SDATA_OE_o,
  output logic             FRAME_DONE_o,
  output logic             BUSY_o,
  output logic [7:0]       POLL_CNT_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'(NBITS - 1);
  localparam logic [4:0] ALL_BITS = 5'(NBITS);

  logic [SYNC_STAGES-1:0] lat_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic                   lat_prev_q;
  logic                   clk_prev_q;
  logic                   lat_rise_s;
  logic                   lat_fall_s;
  logic                   clk_rise_s;

  state_t           state_q, state_d;
  logic [NBITS-1:0] sr_q, sr_d;
  logic [4:0]       bitcnt_q, bitcnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       poll_q, poll_d;
  logic             sdata_q;
  logic             oe_q;

  // Synchronizers reset to the console's idle levels so release from reset
  // never looks like an edge.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      lat_sync_q <= '0;
      clk_sync_q <= '1;
      lat_prev_q <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      lat_sync_q <= {lat_sync_q[SYNC_STAGES-2:0], CTRL_LATCH_i};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], CTRL_CLK_i};
      lat_prev_q <= lat_sync_q[SYNC_STAGES-1];
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign lat_rise_s = lat_sync_q[SYNC_STAGES-1] & ~lat_prev_q;
  assign lat_fall_s = ~lat_sync_q[SYNC_STAGES-1] & lat_prev_q;
  assign clk_rise_s = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    poll_d   = poll_q;
    if (lat_rise_s) begin
      // A new latch always wins: aborts any frame and swallows a coincident clock edge.
      state_d = ST_LOAD;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (lat_fall_s) begin
            state_d  = ST_SHIFT;
            bitcnt_d = 5'd0;
            busy_d   = 1'b1;
          end else begin
            sr_d = BUTTONS_i;
          end
        end
        ST_SHIFT: begin
          if (clk_rise_s) begin
            sr_d = {1'b1, sr_q[NBITS-1:1]};
            if (bitcnt_q == LAST_BIT) begin
              bitcnt_d = ALL_BITS;
              done_d   = 1'b1;
              poll_d   = poll_q + 8'd1;
              busy_d   = 1'b0;
              state_d  = ST_IDLE;
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end else begin
            sr_d = sr_q;
          end
        end
        ST_IDLE: begin
          if (clk_rise_s) begin
            sr_d = {1'b1, sr_q[NBITS-1:1]};
          end else begin
            sr_d = sr_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      bitcnt_q <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      poll_q   <= 8'd0;
      sdata_q  <= 1'b1;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      poll_q   <= poll_d;
      sdata_q  <= ~sr_q[0];
      oe_q     <= 1'b1;
    end
  end

  assign CTRL_SDATA_o    = sdata_q;
  assign CTRL_SDATA_OE_o = oe_q;
  assign FRAME_DONE_o    = done_q;
  assign BUSY_o          = busy_q;
  assign POLL_CNT_o      = poll_q;

endmodule

// File: tb/tb_snes_pad_tx.sv
// Self-checking bench for snes_pad_tx: a queue-based model of the pad protocol
// checked every settled cycle, plus literal expectations per scenario.
module tb_snes_pad_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        latch;
  logic        cclk;
  logic [15:0] btn;
  logic        sdata;
  logic        oe;
  logic        done;
  logic        busy;
  logic [7:0]  poll;

  always #5 clk = ~clk;

  snes_pad_tx #(.SYNC_STAGES(2), .NBITS(16)) dut (
    .CLK_i          (clk),
    .RST_i          (rst),
    .CTRL_LATCH_i   (latch),
    .CTRL_CLK_i     (cclk),
    .BUTTONS_i      (btn),
    .CTRL_SDATA_o   (sdata),
    .CTRL_SDATA_OE_o(oe),
    .FRAME_DONE_o   (done),
    .BUSY_o         (busy),
    .POLL_CNT_o     (poll)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_chg = 0;
  int done_cnt = 0;
  bit rst_seen = 1'b0;

  // Pad model: bits still to send, frame progress, completed-frame counters.
  bit q_bits[$];
  bit latch_hi;
  bit in_frame;
  int sent;
  int exp_poll;
  int exp_done;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit model_line();
    if (latch_hi) return ~btn[0];
    if (q_bits.size() > 0) return ~q_bits[0];
    return 1'b0;
  endfunction

  task automatic model_reset();
    q_bits.delete();
    for (int i = 0; i < 16; i++) q_bits.push_back(1'b0);
    latch_hi = 1'b0;
    in_frame = 1'b0;
    sent     = 0;
    exp_poll = 0;
  endtask

  task automatic compare_loop();
    forever begin
      @(posedge clk);
      rst_seen = rst;
      cyc++;
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (rst_seen) begin
        check("rst_sdata", sdata, 1);
        check("rst_oe", oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_poll", poll, 0);
      end else if (!rst && (cyc - last_chg) >= 5) begin
        check("line", sdata, model_line());
        check("oe", oe, 1);
        check("busy", busy, in_frame);
        check("done_idle", done, 0);
        check("poll", poll, exp_poll);
      end
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    last_chg = cyc;
    model_reset();
    tick(n);
    rst = 1'b0;
    last_chg = cyc;
  endtask

  task automatic set_btn(logic [15:0] v);
    btn = v;
    if (latch_hi) last_chg = cyc;
  endtask

  task automatic latch_rise();
    latch = 1'b1;
    last_chg = cyc;
    latch_hi = 1'b1;
    in_frame = 1'b0;
  endtask

  task automatic latch_fall();
    latch = 1'b0;
    last_chg = cyc;
    latch_hi = 1'b0;
    q_bits.delete();
    for (int i = 0; i < 16; i++) q_bits.push_back(btn[i]);
    in_frame = 1'b1;
    sent = 0;
  endtask

  task automatic model_clk_rise();
    if (!latch_hi) begin
      if (q_bits.size() > 0) void'(q_bits.pop_front());
      if (in_frame) begin
        sent++;
        if (sent == 16) begin
          in_frame = 1'b0;
          exp_poll = (exp_poll + 1) % 256;
          exp_done++;
        end
      end
    end
  endtask

  // Console clocks: the line is sampled at the end of each low phase, as a console would.
  task automatic clock_bits(int n, int h, output logic [31:0] seen);
    seen = 32'd0;
    for (int i = 0; i < n; i++) begin
      cclk = 1'b0;
      last_chg = cyc;
      tick(h);
      seen[i] = sdata;
      cclk = 1'b1;
      last_chg = cyc;
      model_clk_rise();
      tick(h);
    end
  endtask

  task automatic frame(logic [15:0] v, int h, int n, output logic [31:0] seen);
    set_btn(v);
    latch_rise();
    tick(2 * h);
    latch_fall();
    tick(h);
    clock_bits(n, h, seen);
  endtask

  initial begin
    logic [31:0] seen;
    int d0;
    rst   = 1'b1;
    latch = 1'b0;
    cclk  = 1'b1;
    btn   = 16'h0000;
    model_reset();
    fork
      compare_loop();
    join_none

    // Reset
    do_reset(4);
    tick(1);
    check("oe_after_reset", oe, 1);
    check("sdata_after_reset", sdata, 1);
    check("poll_after_reset", poll, 0);

    // Full frame with B and A pressed
    d0 = done_cnt;
    set_btn(16'h0101);
    latch_rise();
    tick(24);
    latch_fall();
    tick(8);
    check("busy_in_frame", busy, 1);
    clock_bits(16, 8, seen);
    check("frame_0101_bits", seen[15:0], 32'h0000FEFE);
    check("frame_0101_done", done_cnt - d0, 1);
    check("frame_0101_poll", poll, 8'd1);
    check("frame_0101_busy", busy, 0);
    tick(2);
    check("line_low_after_frame", sdata, 0);

    // Live tracking during latch, capture of the last value
    d0 = done_cnt;
    set_btn(16'h0001);
    latch_rise();
    tick(8);
    check("live_pressed", sdata, 0);
    set_btn(16'h0000);
    tick(8);
    check("live_released", sdata, 1);
    set_btn(16'h0001);
    tick(8);
    check("live_pressed2", sdata, 0);
    set_btn(16'h0000);
    tick(2);
    latch_fall();
    tick(8);
    clock_bits(16, 8, seen);
    check("live_bit0", seen[0], 1);
    check("live_bits", seen[15:0], 32'h0000FFFF);
    check("live_poll", poll, 8'd2);
    check("live_done", done_cnt - d0, 1);

    // Overclock: 20 clocks, trailing bits read as pressed
    d0 = done_cnt;
    frame(16'h0000, 8, 20, seen);
    check("over_bits", seen[19:0], 32'h000FFFFF & 32'h0000FFFF);
    check("over_done", done_cnt - d0, 1);
    check("over_poll", poll, 8'd3);

    // Abort after 7 clocks, then a normal frame
    d0 = done_cnt;
    frame(16'h0F0F, 8, 7, seen);
    check("abort_bits", seen[6:0], 32'h00000070);
    frame(16'h8001, 8, 16, seen);
    check("after_abort_bits", seen[15:0], 32'h00007FFE);
    check("after_abort_done", done_cnt - d0, 1);
    check("after_abort_poll", poll, 8'd4);

    // Latch rise coincident with a clock rise mid-frame
    d0 = done_cnt;
    frame(16'h1234, 8, 5, seen);
    cclk = 1'b0;
    last_chg = cyc;
    tick(8);
    set_btn(16'hA5A5);
    latch = 1'b1;
    cclk  = 1'b1;
    last_chg = cyc;
    latch_hi = 1'b1;
    in_frame = 1'b0;
    tick(16);
    check("coll_tracks", sdata, 0);
    check("coll_busy", busy, 0);
    latch_fall();
    tick(8);
    clock_bits(16, 8, seen);
    check("coll_frame_bits", seen[15:0], 32'h00005A5A);
    check("coll_done", done_cnt - d0, 1);
    check("coll_poll", poll, 8'd5);

    // Reset mid-frame drops the frame
    d0 = done_cnt;
    frame(16'hFFFF, 8, 5, seen);
    do_reset(2);
    tick(1);
    check("midrst_poll", poll, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sdata", sdata, 1);
    check("midrst_done", done_cnt - d0, 0);

    // 256 frames wrap the poll counter
    d0 = done_cnt;
    for (int f = 0; f < 256; f++) frame(16'h5A3C, 4, 16, seen);
    tick(8);
    check("wrap_poll", poll, 8'd0);
    check("wrap_done", done_cnt - d0, 256);
    check("model_done_total", done_cnt, exp_done);
    check("wrap_last_bits", seen[15:0], 32'h0000A5C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
